video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the HDMI/DVI output path. Runs in the pixel clock domain.
- Produces hsync, vsync, data-enable, pixel coordinates, and an early pixel-request strobe so upstream frame or tile sources can prefetch data.
- Generalises the fixed 640x480@60 timing to any mode set by parameters, with selectable sync polarity.
- Adds a run/stop control that always finishes the current frame before stopping.

---
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/video_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Video timing bus: run request in, raster timing, coordinates, pixel request and pattern out.
// master = timing generator, slave = downstream consumer / upstream pixel source.
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          req;
    logic          frame_start;
    logic          line_start;
    logic          running;
    logic [23:0]   rgb;

    modport master (
        input  en,
        output hsync, vsync, de, x, y, req, frame_start, line_start, running, rgb
    );

    modport slave (
        output en,
        input  hsync, vsync, de, x, y, req, frame_start, line_start, running, rgb
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with run/stop control that always completes the frame.
// Define VIDEO_TIMING_PATTERN_EN to drive an 8-bar colour test pattern on rgb (otherwise rgb = 0).
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int LEAD     = 2,
    parameter int CW       = 12
) (
    input  logic               clk,
    input  logic               sys_reset,
    video_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] LEAD_C   = CW'(LEAD);

    localparam logic HS_ACT = (H_POL != 0);
    localparam logic VS_ACT = (V_POL != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CW-1:0] lh_q, lh_d, lv_q, lv_d;
    logic          lwrap_q, lwrap_d;

    logic          de_q, hs_q, vs_q, req_q, fs_q, ls_q, run_q;
    logic [CW-1:0] x_q, y_q;

    logic active, h_last, v_last, lh_last, lv_last;
    logic de_c, req_c, hs_c, vs_c;

    assign active  = (state_q != S_IDLE);
    assign h_last  = (hcnt_q == H_LAST_C);
    assign v_last  = (vcnt_q == V_LAST_C);
    assign lh_last = (lh_q == H_LAST_C);
    assign lv_last = (lv_q == V_LAST_C);

    assign de_c = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    assign hs_c = (hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C);
    assign vs_c = (vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C);
    // Once the lead counter has wrapped into the next frame, only request if we are going to keep running.
    assign req_c = (lh_q < H_ACT_C) && (lv_q < V_ACT_C) && (!lwrap_q || bus.en);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        lh_d    = lh_q;
        lv_d    = lv_q;
        lwrap_d = lwrap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.en) state_d = S_RUN;
                hcnt_d  = '0;
                vcnt_d  = '0;
                lh_d    = LEAD_C;
                lv_d    = '0;
                lwrap_d = 1'b0;
            end
            S_RUN, S_DRAIN: begin
                // en is only decisive on the last cycle of a frame; elsewhere it just selects RUN/DRAIN.
                if (h_last && v_last) state_d = bus.en ? S_RUN : S_IDLE;
                else                  state_d = bus.en ? S_RUN : S_DRAIN;
                hcnt_d = h_last ? '0 : hcnt_q + CW'(1);
                if (h_last) vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
                lh_d = lh_last ? '0 : lh_q + CW'(1);
                if (lh_last) lv_d = lv_last ? '0 : lv_q + CW'(1);
                if (lh_last && lv_last)    lwrap_d = 1'b1;
                else if (h_last && v_last) lwrap_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            lh_q    <= LEAD_C;
            lv_q    <= '0;
            lwrap_q <= 1'b0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_ACT;
            vs_q    <= ~VS_ACT;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            run_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            lh_q    <= lh_d;
            lv_q    <= lv_d;
            lwrap_q <= lwrap_d;
            de_q    <= active && de_c;
            hs_q    <= (active && hs_c) ? HS_ACT : ~HS_ACT;
            vs_q    <= (active && vs_c) ? VS_ACT : ~VS_ACT;
            req_q   <= active && req_c;
            fs_q    <= active && (hcnt_q == '0) && (vcnt_q == '0);
            ls_q    <= active && (hcnt_q == '0);
            run_q   <= active;
            x_q     <= (active && de_c) ? hcnt_q : '0;
            y_q     <= (active && de_c) ? vcnt_q : '0;
        end
    end

    assign bus.de          = de_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.req         = req_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
    assign bus.running     = run_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;

`ifdef VIDEO_TIMING_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [6:0]  bar_ge;
    logic [2:0]  bar;
    logic [23:0] color;
    logic        frame_odd_q;
    logic [23:0] rgb_q;

    // Thermometer of bar boundaries; the last bar takes whatever remains of the line.
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar
        assign bar_ge[gi] = (hcnt_q >= CW'((gi + 1) * BAR_W));
    end

    assign bar = 3'($countones(bar_ge));

    always_comb begin
        color = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        if ((bar == 3'd0) && (vcnt_q == '0) && frame_odd_q) color = ~color;
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            frame_odd_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            if (active && h_last && v_last) frame_odd_q <= ~frame_odd_q;
            rgb_q <= (active && de_c) ? color : '0;
        end
    end

    assign bus.rgb = rgb_q;
`else
    assign bus.rgb = 24'h0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: small 8x6 mode (instance a) and a small active-high-sync mode (instance b).
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(12)) bus_a ();
    video_timing_gen_if #(.CW(12)) bus_b ();

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0), .LEAD(2), .CW(12)
    ) dut_a (
        .clk       (clk),
        .sys_reset (rst_a),
        .bus       (bus_a.master)
    );

    video_timing_gen #(
        .H_ACTIVE(18), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1), .V_POL(1), .LEAD(3), .CW(12)
    ) dut_b (
        .clk       (clk),
        .sys_reset (rst_b),
        .bus       (bus_b.master)
    );

    // {de, hsync, vsync, line_start, frame_start, req, running}
    wire [6:0]  obs_a = {bus_a.de, bus_a.hsync, bus_a.vsync, bus_a.line_start,
                         bus_a.frame_start, bus_a.req, bus_a.running};
    wire [23:0] xy_a  = {bus_a.x, bus_a.y};
    wire [6:0]  obs_b = {bus_b.de, bus_b.hsync, bus_b.vsync, bus_b.line_start,
                         bus_b.frame_start, bus_b.req, bus_b.running};

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs of instance a, k cycles after the first frame_start.
    // Line of 8: de at h0..3, hsync low at h5,6; frame of 6 lines: de on v0..2, vsync low on v4.
    // req masks: pixels 2,3 of the line at h0,1 and pixels 0,1 of the next line at h6,7.
    function automatic logic [6:0] exp_a(int k, bit stopping);
        int h;
        int v;
        logic [7:0] de_m;
        logic [7:0] hs_m;
        logic [7:0] req_m;
        h = k % 8;
        v = (k / 8) % 6;
        de_m = (v < 3) ? 8'h0F : 8'h00;
        hs_m = 8'h60;
        case (v)
            0, 1:    req_m = 8'hC3;
            2:       req_m = 8'h03;
            5:       req_m = stopping ? 8'h00 : 8'hC0;
            default: req_m = 8'h00;
        endcase
        return {de_m[h], ~hs_m[h], (v != 4), (h == 0), (h == 0 && v == 0), req_m[h], 1'b1};
    endfunction

    function automatic logic [23:0] exp_xy_a(int k);
        int h;
        int v;
        h = k % 8;
        v = (k / 8) % 6;
        if (h < 4 && v < 3) return {12'(h), 12'(v)};
        return 24'h0;
    endfunction

    task automatic test_reset();
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        total++;
        if (obs_a !== 7'b0110000 || xy_a !== 24'h0 || bus_a.rgb !== 24'h0) begin
            bad++;
            $display("FAIL reset_a: obs=%b xy=%h rgb=%h required obs=0110000 xy=0 rgb=0", obs_a, xy_a, bus_a.rgb);
        end
        total++;
        if (obs_b !== 7'b0000000 || bus_b.rgb !== 24'h0) begin
            bad++;
            $display("FAIL reset_b: obs=%b rgb=%h required obs=0000000 rgb=0", obs_b, bus_b.rgb);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (obs_a !== 7'b0110000 || xy_a !== 24'h0) begin
            bad++;
            $display("FAIL idle_no_en: obs=%b xy=%h required obs=0110000 xy=0", obs_a, xy_a);
        end
        $display("test_reset done");
    endtask

    task automatic test_frame_timing();
        int de_cnt;
        int req_cnt;
        int fs_cnt;
        de_cnt = 0;
        req_cnt = 0;
        fs_cnt = 0;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.en = 1'b1;
        tick();
        total++;
        if (bus_a.frame_start !== 1'b0) begin
            bad++;
            $display("FAIL fs_latency_1: frame_start=%b required 0", bus_a.frame_start);
        end
        tick();
        for (int k = 0; k < 96; k++) begin
            total++;
            if (obs_a !== exp_a(k, 1'b0)) begin
                bad++;
                $display("FAIL timing k=%0d: obs=%b required %b", k, obs_a, exp_a(k, 1'b0));
            end
            total++;
            if (xy_a !== exp_xy_a(k)) begin
                bad++;
                $display("FAIL coord k=%0d: xy=%h required %h", k, xy_a, exp_xy_a(k));
            end
            if (k >= 46 && k < 94) req_cnt += int'(bus_a.req);
            if (k >= 48) de_cnt += int'(bus_a.de);
            fs_cnt += int'(bus_a.frame_start);
            tick();
        end
        total++;
        if (req_cnt != 12 || de_cnt != 12 || fs_cnt != 2) begin
            bad++;
            $display("FAIL frame_counts: req=%0d de=%0d fs=%0d required 12 12 2", req_cnt, de_cnt, fs_cnt);
        end
        $display("test_frame_timing done: req=%0d de=%0d fs=%0d", req_cnt, de_cnt, fs_cnt);
    endtask

    task automatic test_stop();
        int de_cnt;
        logic [6:0] want;
        de_cnt = 0;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.en = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 120; k++) begin
            want = (k < 96) ? exp_a(k, k >= 48) : 7'b0110000;
            total++;
            if (obs_a !== want) begin
                bad++;
                $display("FAIL stop k=%0d: obs=%b required %b", k, obs_a, want);
            end
            if (k >= 48) de_cnt += int'(bus_a.de);
            if (k == 71) bus_a.en = 1'b0;
            tick();
        end
        total++;
        if (de_cnt != 12) begin
            bad++;
            $display("FAIL stop_de_count: de=%0d required 12", de_cnt);
        end
        $display("test_stop done: frame2 de=%0d", de_cnt);
    endtask

    task automatic test_en_glitch();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.en = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 96; k++) begin
            total++;
            if (obs_a !== exp_a(k, 1'b0)) begin
                bad++;
                $display("FAIL glitch k=%0d: obs=%b required %b", k, obs_a, exp_a(k, 1'b0));
            end
            if (k == 20) bus_a.en = 1'b0;
            if (k == 21) bus_a.en = 1'b1;
            tick();
        end
        $display("test_en_glitch done");
    endtask

    task automatic test_async_reset();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.en = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 8; k++) tick();
        total++;
        if (bus_a.line_start !== 1'b1 || bus_a.de !== 1'b1) begin
            bad++;
            $display("FAIL async_pre: line_start=%b de=%b required 1 1", bus_a.line_start, bus_a.de);
        end
        #2 rst_a = 1'b1;
        #1;
        total++;
        if (obs_a !== 7'b0110000 || xy_a !== 24'h0 || bus_a.rgb !== 24'h0) begin
            bad++;
            $display("FAIL async_reset: obs=%b xy=%h rgb=%h required obs=0110000 xy=0 rgb=0", obs_a, xy_a, bus_a.rgb);
        end
        tick();
        rst_a = 1'b0;
        tick();
        total++;
        if (bus_a.frame_start !== 1'b0) begin
            bad++;
            $display("FAIL async_fs_early: frame_start=%b required 0", bus_a.frame_start);
        end
        tick();
        total++;
        if (obs_a !== exp_a(0, 1'b0)) begin
            bad++;
            $display("FAIL async_fs: obs=%b required %b", obs_a, exp_a(0, 1'b0));
        end
        $display("test_async_reset done");
    endtask

    task automatic test_polarity();
        int h;
        int v;
        int de_cnt;
        int hs_cnt;
        int vs_cnt;
        logic [3:0]  want;
        logic [23:0] want_rgb;
        de_cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        bus_b.en = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 520; k++) begin
            h = k % 26;
            v = (k / 26) % 10;
            want = {(h < 18 && v < 6), (h >= 20 && h < 23), (v == 7 || v == 8), (k % 260 == 0)};
            total++;
            if ({bus_b.de, bus_b.hsync, bus_b.vsync, bus_b.frame_start} !== want) begin
                bad++;
                $display("FAIL pol k=%0d: de/hs/vs/fs=%b required %b", k,
                         {bus_b.de, bus_b.hsync, bus_b.vsync, bus_b.frame_start}, want);
            end
            want_rgb = 24'h0;
`ifdef VIDEO_TIMING_PATTERN_EN
            if (want[3]) begin
                want_rgb = bars[(h / 2 > 7) ? 7 : h / 2];
                if (h < 2 && v == 0 && k >= 260) want_rgb = ~want_rgb;
            end
`endif
            total++;
            if (bus_b.rgb !== want_rgb) begin
                bad++;
                $display("FAIL rgb k=%0d x=%0d y=%0d: rgb=%h required %h", k, h, v, bus_b.rgb, want_rgb);
            end
            if (k < 260) begin
                de_cnt += int'(bus_b.de);
                hs_cnt += int'(bus_b.hsync);
                vs_cnt += int'(bus_b.vsync);
            end
            tick();
        end
        total++;
        if (de_cnt != 108 || hs_cnt != 30 || vs_cnt != 52) begin
            bad++;
            $display("FAIL pol_counts: de=%0d hs=%0d vs=%0d required 108 30 52", de_cnt, hs_cnt, vs_cnt);
        end
        $display("test_polarity done: de=%0d hs=%0d vs=%0d", de_cnt, hs_cnt, vs_cnt);
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_stop();
        test_en_glitch();
        test_async_reset();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
